// File: rtl/mvu_pkg.sv
// Shared helpers for the MVU processing-element datapath.
// Latency: none (functions and constants only).
// Backpressure: not applicable.
//
// Contents:
//   cnt_width() - width of a counter that must hold values 0..depth-1.
//   lane_sext() - pull one two's-complement lane out of a packed beat and
//                 sign-extend it to LANE_EXT_W bits.
package mvu_pkg;

    // Working widths for the lane helper. Callers zero-extend their packed
    // beat to LANE_BUF_W and truncate the result back to their own width,
    // so one function serves every parameterisation up to these limits.
    localparam int LANE_BUF_W = 1024;
    localparam int LANE_EXT_W = 64;

    // Counter width for a modulo-depth counter; never narrower than 1 bit
    // so a depth of 1 still yields a legal (constant-zero) register.
    function automatic int cnt_width(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

    // Lane idx occupies bits [idx*w +: w]. Shift it down to bit 0, park its
    // sign bit at the top of the word, then shift back arithmetically.
    function automatic logic signed [LANE_EXT_W-1:0] lane_sext(
        input logic [LANE_BUF_W-1:0] data,
        input int                    idx,
        input int                    w
    );
        logic [LANE_EXT_W-1:0] raw;
        raw = LANE_EXT_W'(data >> (idx * w));
        return $signed(raw << (LANE_EXT_W - w)) >>> (LANE_EXT_W - w);
    endfunction

endpackage

// File: rtl/mvu_pe_adder_tree.sv
// Sign-extends every product lane of one beat to TO bits and sums them.
// Latency: 0 cycles (purely combinational; the caller registers the sum).
// Backpressure: none; the output follows in_data every cycle.
//
// Ports:
//   in_data - SIMD packed products, lane i at [i*TDstI +: TDstI]
//   sum     - sum of all lanes, TO bits, two's complement, wraps mod 2^TO
module mvu_pe_adder_tree
    import mvu_pkg::*;
#(
    parameter int SIMD  = 4,
    parameter int TDstI = 2,
    parameter int TO    = 16
) (
    input  logic [SIMD*TDstI-1:0] in_data,
    output logic [TO-1:0]         sum
);

    logic [LANE_BUF_W-1:0] data_ext;

    assign data_ext = LANE_BUF_W'(in_data);

    // A linear chain of adders; synthesis rebalances it into a tree.
    always_comb begin
        sum = '0;
        for (int i = 0; i < SIMD; i++) begin
            sum = sum + TO'(lane_sext(data_ext, i, TDstI));
        end
    end

endmodule

// File: rtl/mvu_pe_acc.sv
// Two-stage PE accumulator: lane sum per beat, then fold SF beats into one dot product.
// Latency: 2 cycles from the accepting edge's input cycle to out_v (one edge per stage).
// Backpressure: out_v && !out_rdy freezes every register and drops in_rdy; nothing is lost.
//
// Ports:
//   clk, rst          - clock; asynchronous active-high reset
//   in_v / in_rdy     - input beat handshake
//   in_data           - SIMD packed TDstI-bit products
//   out_v / out_rdy   - result handshake
//   out_acc           - completed dot product, TO bits, two's complement
module mvu_pe_acc
    import mvu_pkg::*;
#(
    parameter int SIMD  = 4,
    parameter int TDstI = 2,
    parameter int TO    = 16,
    parameter int SF    = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_v,
    output logic                  in_rdy,
    input  logic [SIMD*TDstI-1:0] in_data,
    output logic                  out_v,
    input  logic                  out_rdy,
    output logic [TO-1:0]         out_acc
);

    localparam int                CNT_W    = cnt_width(SF);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SF - 1);

    // Flow control
    logic stall;
    logic accept;

    // Combinational lane sum of the incoming beat
    logic [TO-1:0] tree_sum;

    // Stage 1: registered lane sum
    logic          s1_v_q,   s1_v_d;
    logic [TO-1:0] s1_sum_q, s1_sum_d;

    // Stage 2: fold accumulator and result register
    logic [TO-1:0]    acc_q,     acc_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic             out_v_q,   out_v_d;
    logic [TO-1:0]    out_acc_q, out_acc_d;
    logic [TO-1:0]    next_sum;

    assign stall  = out_v_q && !out_rdy;
    assign in_rdy = !stall;
    assign accept = in_v && in_rdy;

    mvu_pe_adder_tree #(
        .SIMD  (SIMD),
        .TDstI (TDstI),
        .TO    (TO)
    ) u_adder_tree (
        .in_data (in_data),
        .sum     (tree_sum)
    );

    always_comb begin
        s1_v_d    = s1_v_q;
        s1_sum_d  = s1_sum_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        out_v_d   = out_v_q;
        out_acc_d = out_acc_q;
        next_sum  = '0;

        // Under stall every register keeps its value, including a beat
        // already parked in stage 1, so it is consumed once the stall lifts.
        if (!stall) begin
            s1_v_d = accept;
            if (accept) begin
                s1_sum_d = tree_sum;
            end

            // Not stalled means either no result is pending or it is being
            // taken this cycle; a result loaded below overrides this.
            out_v_d = 1'b0;

            if (s1_v_q) begin
                // Fold beat 0 starts fresh, so acc never needs an explicit
                // clear between folds; overflow wraps mod 2^TO.
                next_sum = (cnt_q == '0) ? s1_sum_q : acc_q + s1_sum_q;

                if (cnt_q == CNT_LAST) begin
                    out_acc_d = next_sum;
                    out_v_d   = 1'b1;
                    cnt_d     = '0;
                end else begin
                    acc_d = next_sum;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v_q    <= 1'b0;
            s1_sum_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            out_v_q   <= 1'b0;
            out_acc_q <= '0;
        end else begin
            s1_v_q    <= s1_v_d;
            s1_sum_q  <= s1_sum_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            out_v_q   <= out_v_d;
            out_acc_q <= out_acc_d;
        end
    end

    assign out_v   = out_v_q;
    assign out_acc = out_acc_q;

endmodule

// File: tb/tb_mvu_pe_acc.sv
// Directed bench for mvu_pe_acc: default, narrow-accumulator and SF=1 instances.
// Latency: checks exact out_v timing on the default instance.
// Backpressure: exercises a held out_rdy with a continuing input stream.
module tb_mvu_pe_acc;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    // u0: defaults (SIMD=4, TDstI=2, TO=16, SF=3)
    logic        v0    = 1'b0;
    logic        rdy0;
    logic [7:0]  d0    = '0;
    logic        ov0;
    logic        ordy0 = 1'b1;
    logic [15:0] acc0;

    // u1: TO=4, SF=3
    logic        v1    = 1'b0;
    logic        rdy1;
    logic [7:0]  d1    = '0;
    logic        ov1;
    logic        ordy1 = 1'b1;
    logic [3:0]  acc1;

    // u2: SF=1
    logic        v2    = 1'b0;
    logic        rdy2;
    logic [7:0]  d2    = '0;
    logic        ov2;
    logic        ordy2 = 1'b1;
    logic [15:0] acc2;

    mvu_pe_acc #(.SIMD(4), .TDstI(2), .TO(16), .SF(3)) u0 (
        .clk(clk), .rst(rst), .in_v(v0), .in_rdy(rdy0), .in_data(d0),
        .out_v(ov0), .out_rdy(ordy0), .out_acc(acc0)
    );

    mvu_pe_acc #(.SIMD(4), .TDstI(2), .TO(4), .SF(3)) u1 (
        .clk(clk), .rst(rst), .in_v(v1), .in_rdy(rdy1), .in_data(d1),
        .out_v(ov1), .out_rdy(ordy1), .out_acc(acc1)
    );

    mvu_pe_acc #(.SIMD(4), .TDstI(2), .TO(16), .SF(1)) u2 (
        .clk(clk), .rst(rst), .in_v(v2), .in_rdy(rdy2), .in_data(d2),
        .out_v(ov2), .out_rdy(ordy2), .out_acc(acc2)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_val(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Completed handshakes, sampled mid-cycle; inputs only move just after
    // posedge, so what is seen here is what the next edge transfers.
    int q0[$];
    int q1[$];
    int q2[$];

    always @(negedge clk) begin
        if (ov0 && ordy0) q0.push_back(int'($signed(acc0)));
        if (ov1 && ordy1) q1.push_back(int'($signed(acc1)));
        if (ov2 && ordy2) q2.push_back(int'($signed(acc2)));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Backpressure stream for u0: offers beats from b3 in order, advancing
    // only when the beat is actually accepted.
    logic [7:0] b3 [9] = '{8'h55, 8'h55, 8'h55, 8'hAA, 8'hAA, 8'hAA, 8'h8D, 8'h8D, 8'h8D};
    int         e3 [3] = '{12, -24, -6};
    int         idx3   = 0;

    task automatic drive_stream(input int n_cycles);
        for (int c = 0; c < n_cycles; c++) begin
            if (idx3 < 9) begin
                v0 = 1'b1;
                d0 = b3[idx3];
            end else begin
                v0 = 1'b0;
            end
            @(negedge clk);
            if (v0 && rdy0) idx3++;
            @(posedge clk);
            #1;
        end
    endtask

    // SF=1 pattern with idle gaps; lane sums worked out per entry:
    // 55 -> +4, AA -> -8, 8D -> +1-1+0-2 = -2, FF -> -4, 71 -> +1+0-1+1 = +1, 00 -> 0
    logic       t6v [11] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [7:0] t6d [11] = '{8'h55, 8'hAA, 8'hAA, 8'h8D, 8'h55, 8'hFF, 8'hFF, 8'h71, 8'h00, 8'h71, 8'h55};
    int         e6  [7]  = '{4, -8, -2, -4, 1, 0, 4};

    logic [7:0] t2 [6] = '{8'hAA, 8'hAA, 8'hAA, 8'h55, 8'h55, 8'h55};

    int base;

    initial begin
        // ---------------- reset state ----------------
        tick();
        tick();
        check_val("rst_in_rdy", int'(rdy0), 1);
        check_val("rst_out_v", int'(ov0), 0);
        check_val("rst_out_acc", int'(acc0), 0);
        rst = 1'b0;

        // ---------------- three +1 beats, latency ----------------
        for (int k = 0; k < 3; k++) begin
            v0 = 1'b1;
            d0 = 8'h55;
            tick();
        end
        v0 = 1'b0;
        check_val("lat_not_early", int'(ov0), 0);
        tick();
        check_val("lat_out_v", int'(ov0), 1);
        check_val("lat_out_acc", int'($signed(acc0)), 12);
        tick();
        check_val("lat_out_v_clear", int'(ov0), 0);

        // ---------------- -2 fold then +1 fold, back to back ----------------
        for (int k = 0; k < 6; k++) begin
            v0 = 1'b1;
            d0 = t2[k];
            tick();
            if (k == 3) begin
                check_val("b2b_first_v", int'(ov0), 1);
                check_val("b2b_first_acc", int'($signed(acc0)), -24);
            end
            if (k == 4) check_val("b2b_gap", int'(ov0), 0);
        end
        v0 = 1'b0;
        tick();
        check_val("b2b_second_v", int'(ov0), 1);
        check_val("b2b_second_acc", int'($signed(acc0)), 12);
        tick();

        // ---------------- backpressure ----------------
        ordy0 = 1'b0;
        idx3  = 0;
        base  = q0.size();
        drive_stream(8);
        check_val("bp_accepted", idx3, 4);
        check_val("bp_in_rdy", int'(rdy0), 0);
        check_val("bp_out_v_held", int'(ov0), 1);
        check_val("bp_out_acc_held", int'($signed(acc0)), 12);
        check_val("bp_no_handshake", q0.size() - base, 0);
        ordy0 = 1'b1;
        drive_stream(20);
        v0 = 1'b0;
        repeat (4) tick();
        check_val("bp_count", q0.size() - base, 3);
        for (int i = 0; i < 3; i++) begin
            check_val($sformatf("bp_res%0d", i),
                      (q0.size() > base + i) ? q0[base + i] : 32'h7fff_ffff, e3[i]);
        end

        // ---------------- reset mid-fold ----------------
        for (int k = 0; k < 2; k++) begin
            v0 = 1'b1;
            d0 = 8'hAA;
            tick();
        end
        v0  = 1'b0;
        rst = 1'b1;
        #2;
        check_val("mid_rst_async_acc", int'(acc0), 0);
        check_val("mid_rst_out_v", int'(ov0), 0);
        check_val("mid_rst_in_rdy", int'(rdy0), 1);
        tick();
        tick();
        rst  = 1'b0;
        base = q0.size();
        for (int k = 0; k < 3; k++) begin
            v0 = 1'b1;
            d0 = 8'h55;
            tick();
        end
        v0 = 1'b0;
        repeat (4) tick();
        check_val("mid_rst_count", q0.size() - base, 1);
        check_val("mid_rst_result", (q0.size() > base) ? q0[base] : 32'h7fff_ffff, 12);

        // ---------------- TO=4 wrap ----------------
        base = q1.size();
        for (int k = 0; k < 3; k++) begin
            v1 = 1'b1;
            d1 = 8'h55;
            tick();
        end
        v1 = 1'b0;
        repeat (4) tick();
        check_val("wrap_count", q1.size() - base, 1);
        check_val("wrap_signed", (q1.size() > base) ? q1[base] : 32'h7fff_ffff, -4);
        check_val("wrap_raw", int'(acc1), 12);

        // ---------------- SF=1 with idle gaps ----------------
        base = q2.size();
        for (int k = 0; k < 11; k++) begin
            v2 = t6v[k];
            d2 = t6d[k];
            tick();
        end
        v2 = 1'b0;
        repeat (4) tick();
        check_val("sf1_count", q2.size() - base, 7);
        for (int i = 0; i < 7; i++) begin
            check_val($sformatf("sf1_res%0d", i),
                      (q2.size() > base + i) ? q2[base + i] : 32'h7fff_ffff, e6[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
